// File: rtl/seg7_capture.sv
// seg7_capture: receive-side monitor for a 4-digit multiplexed 7-segment bus.
// It waits until each strobed digit is stable for HOLD samples. It then decodes
// the segment pattern back to a 4-bit code and stores it in a per-digit register file.
// The block only observes the bus and never drives the display.
//
// Build option: define SEG7_CAP_SYNC_EN to place a 2-flop synchroniser on
// {SA, LED}. Without it the raw inputs are sampled directly.
//
// Ports:
//   CLK    in   system clock
//   RST    in   asynchronous active-high reset
//   LED    in   [7:0] segments, bit7=A .. bit1=G, bit0=Dp (1 = lit)
//   SA     in   [3:0] one-hot digit select
//   DIGITS out  [15:0] recovered codes, DIGITS[4i+3:4i] = digit i
//   DP     out  [3:0] captured decimal point per digit
//   VALID  out  [3:0] digit holds a fresh, recognised code
//   UPDATE out  one-cycle pulse on any slot write
//   ERR    out  sticky flag for an unrecognised pattern
module seg7_capture #(
  parameter int HOLD      = 4,
  parameter int STALE_CYC = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  LED,
  input  logic [3:0]  SA,
  output logic [15:0] DIGITS,
  output logic [3:0]  DP,
  output logic [3:0]  VALID,
  output logic        UPDATE,
  output logic        ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_WAIT} state_t;

  localparam logic [7:0]  HOLD_C  = 8'(HOLD);
  localparam logic [15:0] STALE_C = 16'(STALE_CYC);

  // Returns {recognised, code} for the A..G segment pattern.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: decode = {1'b1, 4'h0};
      7'b0110000: decode = {1'b1, 4'h1};
      7'b1101101: decode = {1'b1, 4'h2};
      7'b1111001: decode = {1'b1, 4'h3};
      7'b0110011: decode = {1'b1, 4'h4};
      7'b1011011: decode = {1'b1, 4'h5};
      7'b1011111: decode = {1'b1, 4'h6};
      7'b1110010: decode = {1'b1, 4'h7};
      7'b1111111: decode = {1'b1, 4'h8};
      7'b1111011: decode = {1'b1, 4'h9};
      7'b1001111: decode = {1'b1, 4'hE};
      7'b0000000: decode = {1'b1, 4'hF};
      default:    decode = {1'b0, 4'hF};
    endcase
  endfunction

  function automatic logic one_hot(input logic [3:0] v);
    one_hot = (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] sel_index(input logic [3:0] sa);
    case (sa)
      4'b0001: sel_index = 2'd0;
      4'b0010: sel_index = 2'd1;
      4'b0100: sel_index = 2'd2;
      4'b1000: sel_index = 2'd3;
      default: sel_index = 2'd0;
    endcase
  endfunction

  logic [11:0] s;  // current sample {SA, LED}

`ifdef SEG7_CAP_SYNC_EN
  logic [11:0] sync1_q, sync2_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 12'd0;
      sync2_q <= 12'd0;
    end else begin
      sync1_q <= {SA, LED};
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = {SA, LED};
`endif

  state_t      state_q, state_d;
  logic [11:0] ref_q, ref_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  valid_q, valid_d;
  logic        update_q, update_d;
  logic        err_q, err_d;
  logic [15:0] stale_q [4];
  logic [15:0] stale_d [4];

  logic [4:0]  dec;
  logic [1:0]  idx;
  logic [7:0]  cnt_inc;

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    dp_d     = dp_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    err_d    = err_q;
    stale_d  = stale_q;
    dec      = decode(ref_q[7:1]);
    idx      = sel_index(ref_q[11:8]);
    cnt_inc  = cnt_q + 8'd1;

    // Freshness timers age every cycle. A capture below overrides its own slot.
    for (int i = 0; i < 4; i++) begin
      if (stale_q[i] >= STALE_C) begin
        stale_d[i] = STALE_C;
      end else begin
        stale_d[i] = stale_q[i] + 16'd1;
      end
      if (stale_d[i] == STALE_C) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_d[i];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (one_hot(s[11:8])) begin
          ref_d   = s;
          cnt_d   = 8'd1;
          // A single matching sample already satisfies HOLD=1.
          state_d = (HOLD_C == 8'd1) ? ST_CAPTURE : ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (s == ref_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == HOLD_C) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_SETTLE;
          end
        end else if (one_hot(s[11:8])) begin
          ref_d   = s;
          cnt_d   = 8'd1;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        digits_d[{idx, 2'b00} +: 4] = dec[3:0];
        dp_d[idx]    = ref_q[0];
        valid_d[idx] = dec[4];
        stale_d[idx] = 16'd0;
        update_d     = 1'b1;
        if (!dec[4]) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Hold off until the bus moves so a parked digit is not recaptured.
        if (s != ref_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      ref_q    <= 12'd0;
      cnt_q    <= 8'd0;
      digits_q <= 16'h0000;
      dp_q     <= 4'd0;
      valid_q  <= 4'd0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stale_q[i] <= 16'd0;
      end
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
      for (int i = 0; i < 4; i++) begin
        stale_q[i] <= stale_d[i];
      end
    end
  end

  assign DIGITS = digits_q;
  assign DP     = dp_q;
  assign VALID  = valid_q;
  assign UPDATE = update_q;
  assign ERR    = err_q;

endmodule
